pic_fetch_sequencer: RTL and testbench
======================================

Name: pic_fetch_sequencer

Overview:
- Program counter and instruction-fetch controller for the 14-bit-word, 2K-word PIC program ROM.
- Drives the ROM address and registers each fetched word into an execute-stage instruction register.
- Resolves GOTO/CALL/RETURN/RETLW/RETFIE, ALU skip requests and computed PCL writes, with pipeline flush.
- Owns the hardware return stack. Sits between the program ROM and the core decode/ALU.

Parameters:
- STACK_DEPTH, 8, number of return-stack entries (power of 2, circular).
- RESET_VECTOR, 11'h000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold all state: PC, IR, stack, flags.
- rom_data_i  in  14  ROM word at rom_addr_o, combinational.
- rom_addr_o  out  11  fetch address; equals the PC register.
- ir_o  out  14  instruction in execute; 14'h0000 (NOP) when flushed.
- ir_pc_o  out  11  address of ir_o.
- ir_valid_o  out  1  ir_o is a real fetched instruction (not reset or flush filler).
- skip_i  in  1  ALU: current ir_o's test condition requires a skip (BTFSS, DECFSZ, etc.).
- pcl_we_i  in  1  datapath writes PCL this cycle.
- pcl_data_i  in  8  new PCL value.
- pclath_i  in  5  PCLATH; bits [2:0] form PC[10:8] on a PCL write.
- stack_overflow_o  out  1  sticky; set on push while the stack is full.
- stack_underflow_o  out  1  sticky; set on pop while the stack is empty.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - PC=RESET_VECTOR, ir_o=0, ir_pc_o=0, ir_valid_o=0.
  - Stack pointer=0, stack count=0, both flags=0. Stack contents are don't-care.
  - Reset overrides stall_i and every other input. Reset mid-branch discards the branch.
- Pipeline: two stages (fetch, execute).
  - Normal unstalled edge: ir_o<=rom_data_i, ir_pc_o<=PC, ir_valid_o<=1, PC<=PC+1 (11-bit wrap, 0x7FF->0x000).
  - Latency: a word at address A appears on ir_o one edge after rom_addr_o=A.
- Decode of ir_o (acted on only when ir_valid_o=1):
  - GOTO: ir[13:11]=3'b101.
  - CALL: ir[13:11]=3'b100.
  - RETURN: 14'h0008.
  - RETFIE: 14'h0009.
  - RETLW: ir[13:10]=4'b1101.
- Priority per unstalled edge: rst > stall_i > control transfer > skip_i > normal.
- Control transfer: the fetched word is discarded (ir_o<=0, ir_valid_o<=0, ir_pc_o<=new PC). Actions:
  - GOTO: PC<=ir[10:0].
  - CALL: push PC (= ir_pc_o+1), then PC<=ir[10:0].
  - RETURN / RETFIE / RETLW: PC<=pop.
  - pcl_we_i: PC<={pclath_i[2:0], pcl_data_i}. Takes precedence over a simultaneous decoded branch.
- Skip: skip_i=1 with no control transfer gives PC<=PC+1 and a flushed IR (ir_o=0, ir_valid_o=0). The instruction at ir_pc_o+1 is never executed.
  - skip_i is ignored when ir_valid_o=0 or when a control transfer occurs.
- Stall: stall_i=1 freezes all registers. rom_addr_o stays stable. Inputs are ignored.
- Stack: circular array of STACK_DEPTH x 11 bits.
  - Push: write at sp, sp<=sp+1 (mod depth). count<=min(count+1, STACK_DEPTH).
  - Push with count==STACK_DEPTH: overwrites the oldest entry and sets stack_overflow_o.
  - Pop: sp<=sp-1 (mod depth), returns entry[sp-1], count<=count-1.
  - Pop with count==0: still returns entry[sp-1], sp still decrements, count stays 0, sets stack_underflow_o.
  - Flags clear only on rst.
- ROM reads are combinational; no wait states.

Test Plan:
- Reset and linear fetch: ROM 0x000=0x01A5, 0x001=0x01A4; release rst -> edge1: rom_addr_o=0x001, ir_o=0x01A5, ir_pc_o=0x000, ir_valid_o=1; edge2: ir_o=0x01A4, rom_addr_o=0x002.
- GOTO flush: 0x00C=0x2807 reaches ir_o -> next edge: rom_addr_o=0x007, ir_valid_o=0, ir_o=0; following edge: ir_o=word@0x007 (0x0825), ir_pc_o=0x007.
- Skip: ir_o=0x1FA5@0x00B with skip_i=1 -> 0x2807@0x00C flushed (ir_valid_o=0); next edge ir_o=0x280E, ir_pc_o=0x00D; then PC=0x00E.
- CALL/RETLW: CALL 0x018 (0x2018) at 0x005 -> PC=0x018, stack count=1; RETLW 0x3400 at 0x018 -> PC=0x006, one flushed slot, ir_pc_o=0x006 next valid instruction.
- Stack overflow/underflow: 9 nested CALLs -> stack_overflow_o=1 after the 9th, 9th return targets the 1st entry's overwrite; RETURN from empty after reset -> stack_underflow_o=1, both sticky until rst.
- Stall, PCL write and mid-operation reset:
  - stall_i=1 for 3 cycles -> rom_addr_o/ir_o unchanged.
  - pcl_we_i=1, pclath_i=5'h03, pcl_data_i=8'h40, same cycle ir_o=GOTO -> PC=0x340.
  - rst asserted the edge a CALL executes -> PC=0x000, count=0.

Source files
------------

// File: rtl/pic_fetch_sequencer.sv
// PIC program counter, two-stage fetch/execute pipeline and hardware return stack.
// Resolves GOTO/CALL/RETURN/RETFIE/RETLW, ALU skips and PCL writes by flushing the IR.
module pic_fetch_sequencer #(
   parameter int unsigned STACK_DEPTH  = 8,
   parameter logic [10:0] RESET_VECTOR = 11'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic [13:0] rom_data_i,
   output logic [10:0] rom_addr_o,
   output logic [13:0] ir_o,
   output logic [10:0] ir_pc_o,
   output logic        ir_valid_o,
   input  logic        skip_i,
   input  logic        pcl_we_i,
   input  logic [7:0]  pcl_data_i,
   input  logic [4:0]  pclath_i,
   output logic        stack_overflow_o,
   output logic        stack_underflow_o
);

   localparam int unsigned SpW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(STACK_DEPTH);

   logic [10:0]     pc_q, pc_d;
   logic [13:0]     ir_q, ir_d;
   logic [10:0]     ir_pc_q, ir_pc_d;
   logic            ir_valid_q, ir_valid_d;
   logic [SpW-1:0]  sp_q, sp_d, sp_dec;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic [10:0]     stack_q [STACK_DEPTH];

   logic is_goto, is_call, is_ret, do_push, do_pop, xfer, do_skip;

   assign is_goto = ir_valid_q && (ir_q[13:11] == 3'b101);
   assign is_call = ir_valid_q && (ir_q[13:11] == 3'b100);
   assign is_ret  = ir_valid_q && ((ir_q == 14'h0008) || (ir_q == 14'h0009) ||
                                   (ir_q[13:10] == 4'b1101));

   // A PCL write overrides any decoded branch, including its stack side effect.
   assign do_push = !pcl_we_i && is_call;
   assign do_pop  = !pcl_we_i && is_ret;
   assign xfer    = pcl_we_i || is_goto || is_call || is_ret;
   assign do_skip = !xfer && ir_valid_q && skip_i;
   assign sp_dec  = sp_q - SpW'(1);

   always_comb begin
      pc_d       = pc_q + 11'd1;
      ir_d       = rom_data_i;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      sp_d       = sp_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (pcl_we_i) begin
         pc_d = {pclath_i[2:0], pcl_data_i};
      end else if (is_goto || is_call) begin
         pc_d = ir_q[10:0];
      end else if (is_ret) begin
         pc_d = stack_q[sp_dec];
      end

      if (xfer) begin
         ir_d       = 14'h0000;
         ir_valid_d = 1'b0;
         ir_pc_d    = pc_d;
      end else if (do_skip) begin
         ir_d       = 14'h0000;
         ir_valid_d = 1'b0;
      end

      if (do_push) begin
         sp_d = sp_q + SpW'(1);
         if (cnt_q == CntFull) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + CntW'(1);
      end else if (do_pop) begin
         sp_d = sp_dec;
         if (cnt_q == '0) unf_d = 1'b1;
         else             cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VECTOR;
         ir_q       <= 14'h0000;
         ir_pc_q    <= 11'h000;
         ir_valid_q <= 1'b0;
         sp_q       <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else if (!stall_i) begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         sp_q       <= sp_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Stack storage is not reset; a push overwrites the slot at sp (oldest when full).
   always_ff @(posedge clk) begin
      if (!rst && !stall_i && do_push) begin
         stack_q[sp_q] <= pc_q;
      end
   end

   assign rom_addr_o        = pc_q;
   assign ir_o              = ir_q;
   assign ir_pc_o           = ir_pc_q;
   assign ir_valid_o        = ir_valid_q;
   assign stack_overflow_o  = ovf_q;
   assign stack_underflow_o = unf_q;

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Scoreboard bench: directed ROM images push expected executed (pc, word) pairs;
// a monitor pops one entry each time a new valid instruction reaches ir_o.
module tb_pic_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic [13:0] rom_data_i;
   logic [10:0] rom_addr_o;
   logic [13:0] ir_o;
   logic [10:0] ir_pc_o;
   logic        ir_valid_o;
   logic        skip_i = 1'b0;
   logic        pcl_we_i = 1'b0;
   logic [7:0]  pcl_data_i = 8'h00;
   logic [4:0]  pclath_i = 5'h00;
   logic        stack_overflow_o;
   logic        stack_underflow_o;

   logic [13:0] rom [2048];
   assign rom_data_i = rom[rom_addr_o];

   typedef struct {
      logic [10:0] pc;
      logic [13:0] ir;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   pic_fetch_sequencer #(
      .STACK_DEPTH (8),
      .RESET_VECTOR(11'h000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .rom_data_i       (rom_data_i),
      .rom_addr_o       (rom_addr_o),
      .ir_o             (ir_o),
      .ir_pc_o          (ir_pc_o),
      .ir_valid_o       (ir_valid_o),
      .skip_i           (skip_i),
      .pcl_we_i         (pcl_we_i),
      .pcl_data_i       (pcl_data_i),
      .pclath_i         (pclath_i),
      .stack_overflow_o (stack_overflow_o),
      .stack_underflow_o(stack_underflow_o)
   );

   always #5 clk = ~clk;

   // Monitor: a new instruction is presented after any edge that was neither reset nor stall.
   logic mon_rst, mon_stall;
   always begin
      @(posedge clk);
      mon_rst   = rst;
      mon_stall = stall_i;
      #1;
      if (!mon_rst && !mon_stall && ir_valid_o) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL exec: unexpected pc=%03h ir=%04h, scoreboard empty", ir_pc_o, ir_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (ir_pc_o !== e.pc || ir_o !== e.ir) begin
               bad++;
               $display("FAIL exec: got pc=%03h ir=%04h want pc=%03h ir=%04h",
                        ir_pc_o, ir_o, e.pc, e.ir);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [10:0] pc, input logic [13:0] ir);
      exp_t e;
      e.pc = pc;
      e.ir = ir;
      exp_q.push_back(e);
   endtask

   task automatic clr_rom();
      for (int a = 0; a < 2048; a++) rom[a] = 14'h0000;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      stall_i  = 1'b0;
      skip_i   = 1'b0;
      pcl_we_i = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // Reset and linear fetch
      clr_rom();
      rom[0] = 14'h01A5;
      rom[1] = 14'h01A4;
      do_reset();
      chk("rst_addr", 32'(rom_addr_o), 32'h000);
      chk("rst_ir", 32'(ir_o), 32'h0000);
      chk("rst_irpc", 32'(ir_pc_o), 32'h000);
      chk("rst_valid", 32'(ir_valid_o), 32'h0);
      chk("rst_ovf", 32'(stack_overflow_o), 32'h0);
      chk("rst_unf", 32'(stack_underflow_o), 32'h0);
      push_exp(11'h000, 14'h01A5);
      push_exp(11'h001, 14'h01A4);
      step();
      chk("lin_addr1", 32'(rom_addr_o), 32'h001);
      step();
      chk("lin_addr2", 32'(rom_addr_o), 32'h002);

      // GOTO flush
      clr_rom();
      rom[11'h007] = 14'h0825;
      rom[11'h00B] = 14'h1FA5;
      rom[11'h00C] = 14'h2807;
      rom[11'h00D] = 14'h280E;
      do_reset();
      for (int a = 0; a <= 12; a++) push_exp(11'(a), rom[a]);
      push_exp(11'h007, 14'h0825);
      repeat (13) step();
      step();
      chk("goto_addr", 32'(rom_addr_o), 32'h007);
      chk("goto_valid", 32'(ir_valid_o), 32'h0);
      chk("goto_ir", 32'(ir_o), 32'h0000);
      step();

      // Skip of the word at 0x00C
      do_reset();
      for (int a = 0; a <= 11; a++) push_exp(11'(a), rom[a]);
      push_exp(11'h00D, 14'h280E);
      repeat (12) step();
      skip_i = 1'b1;
      step();
      skip_i = 1'b0;
      chk("skip_valid", 32'(ir_valid_o), 32'h0);
      chk("skip_addr", 32'(rom_addr_o), 32'h00D);
      step();
      chk("skip_addr2", 32'(rom_addr_o), 32'h00E);

      // CALL / RETLW
      clr_rom();
      rom[11'h005] = 14'h2018;
      rom[11'h018] = 14'h3400;
      do_reset();
      for (int a = 0; a <= 5; a++) push_exp(11'(a), rom[a]);
      push_exp(11'h018, 14'h3400);
      push_exp(11'h006, 14'h0000);
      repeat (7) step();
      chk("call_addr", 32'(rom_addr_o), 32'h018);
      step();
      step();
      chk("retlw_addr", 32'(rom_addr_o), 32'h006);
      chk("retlw_irpc", 32'(ir_pc_o), 32'h006);
      chk("retlw_valid", 32'(ir_valid_o), 32'h0);
      step();
      chk("retlw_unf", 32'(stack_underflow_o), 32'h0);

      // Nine nested CALLs overflow; the ninth return re-reads the overwritten entry
      clr_rom();
      for (int k = 0; k <= 8; k++) begin
         rom[16 * k]     = 14'(14'h2000 + 16 * (k + 1));
         rom[16 * k + 1] = 14'h0008;
      end
      rom[11'h090] = 14'h0008;
      do_reset();
      for (int k = 0; k <= 8; k++) push_exp(11'(16 * k), rom[16 * k]);
      push_exp(11'h090, 14'h0008);
      for (int k = 8; k >= 1; k--) push_exp(11'(16 * k + 1), 14'h0008);
      push_exp(11'h081, 14'h0008);
      repeat (16) step();
      chk("ovf_8calls", 32'(stack_overflow_o), 32'h0);
      repeat (2) step();
      chk("ovf_9calls", 32'(stack_overflow_o), 32'h1);
      repeat (16) step();
      chk("unf_8pops", 32'(stack_underflow_o), 32'h0);
      repeat (2) step();
      chk("unf_9pops", 32'(stack_underflow_o), 32'h1);
      chk("ovf_sticky", 32'(stack_overflow_o), 32'h1);
      chk("ret9_addr", 32'(rom_addr_o), 32'h081);
      step();

      // RETURN on an empty stack after reset
      clr_rom();
      rom[0] = 14'h0008;
      do_reset();
      chk("reset_clr_ovf", 32'(stack_overflow_o), 32'h0);
      chk("reset_clr_unf", 32'(stack_underflow_o), 32'h0);
      push_exp(11'h000, 14'h0008);
      step();
      step();
      stall_i = 1'b1;
      chk("empty_unf", 32'(stack_underflow_o), 32'h1);
      chk("empty_ovf", 32'(stack_overflow_o), 32'h0);
      repeat (2) step();
      chk("unf_sticky", 32'(stack_underflow_o), 32'h1);

      // Stall holds everything and ignores other inputs
      clr_rom();
      for (int a = 0; a < 8; a++) rom[a] = 14'(14'h0100 + a);
      do_reset();
      for (int a = 0; a <= 3; a++) push_exp(11'(a), rom[a]);
      step();
      step();
      stall_i    = 1'b1;
      skip_i     = 1'b1;
      pcl_we_i   = 1'b1;
      pclath_i   = 5'h1F;
      pcl_data_i = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_addr", 32'(rom_addr_o), 32'h002);
         chk("stall_ir", 32'(ir_o), 32'h0101);
      end
      stall_i  = 1'b0;
      skip_i   = 1'b0;
      pcl_we_i = 1'b0;
      step();
      step();

      // PCL write beats a simultaneous GOTO
      clr_rom();
      rom[0]       = 14'h2923;
      rom[11'h340] = 14'h0155;
      do_reset();
      push_exp(11'h000, 14'h2923);
      push_exp(11'h340, 14'h0155);
      step();
      pcl_we_i   = 1'b1;
      pclath_i   = 5'h03;
      pcl_data_i = 8'h40;
      step();
      pcl_we_i = 1'b0;
      chk("pcl_addr", 32'(rom_addr_o), 32'h340);
      chk("pcl_irpc", 32'(ir_pc_o), 32'h340);
      chk("pcl_valid", 32'(ir_valid_o), 32'h0);
      step();

      // Reset on the edge a CALL executes discards the push
      clr_rom();
      rom[0] = 14'h2050;
      do_reset();
      push_exp(11'h000, 14'h2050);
      push_exp(11'h000, 14'h0008);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstcall_addr", 32'(rom_addr_o), 32'h000);
      chk("rstcall_valid", 32'(ir_valid_o), 32'h0);
      chk("rstcall_ir", 32'(ir_o), 32'h0000);
      rom[0] = 14'h0008;
      step();
      step();
      chk("rstcall_cnt0", 32'(stack_underflow_o), 32'h1);
      rst = 1'b1;
      step();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
